nsdp_check_ctrl: RTL and testbench
==================================

// Module: nsdp_check_ctrl
// PURPOSE
//  Run controller for the NSDP packet checker. Starts and stops check runs.
//  Aligns each run to a packet boundary, counts received packets and latches
//  the first error with its 512-bit data beat. Produces the run_status,
//  eth_active, error, error_data and packets_rcvd values read back over the
//  AXI status registers.
// PARAMETERS
//  DW            512      stream data width (bits)
//  EW            15       checker error-vector width
//  HALT_ON_ERR   1        1 = stop counting after first error; 0 = keep running
//  ACT_TIMEOUT   1000000  idle clk cycles before eth_active drops
// PORTS
//  clk           in   1    clock
//  resetn        in   1    synchronous, active-low reset
//  start         in   1    1-cycle pulse: begin a new run
//  stop          in   1    1-cycle pulse: end the current run
//  axis_tdata    in   DW   monitored stream beat
//  axis_tvalid   in   1    beat valid (monitor only; no backpressure)
//  axis_tlast    in   1    last beat of packet
//  chk_error     in   EW   checker error bits for the current beat (same cycle)
//  chk_init      out  1    1-cycle pulse: checker reloads its expected values
//  run_status    out  1    1 in ARMED or RUNNING
//  eth_active    out  1    beat seen within last ACT_TIMEOUT cycles
//  error         out  EW   first nonzero chk_error of this run (sticky)
//  error_data    out  DW   axis_tdata of the beat that raised error
//  packets_rcvd  out  64   packets completed while RUNNING
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0. sop=1. Activity counter=0.
//  - sop: set on any tvalid&tlast beat; cleared on tvalid&!tlast. Tracked in
//    every state.
//  - States:
//    IDLE    : start -> ARMED. Same cycle: clear error, error_data and
//              packets_rcvd; chk_init=1.
//    ARMED   : first beat with tvalid&sop -> RUNNING. That beat is processed as
//              RUNNING (counted and checked). Beats not at sop are ignored.
//    RUNNING : tvalid&tlast -> packets_rcvd+1 (64-bit, wraps).
//              tvalid & chk_error!=0 & error==0 -> latch error and error_data.
//              If HALT_ON_ERR, go to HALTED.
//    HALTED  : counters frozen; error held; start -> ARMED (same as from IDLE).
//  - stop in ARMED/RUNNING -> IDLE. Results are held, not cleared.
//  - start & stop in the same cycle: stop wins; start is ignored.
//  - start in ARMED/RUNNING: restart. Clear results, pulse chk_init, -> ARMED.
//  - Error beat that is also tlast: the packet is counted, then the error is
//    latched (same cycle).
//  - When HALT_ON_ERR=0, later errors never overwrite error/error_data.
//  - chk_init: registered, asserted exactly 1 cycle after the accepted start.
//  - eth_active: counter reloads ACT_TIMEOUT on any tvalid, otherwise
//    decrements to 0. eth_active = (counter!=0). Independent of state.
//  - Latency: all outputs registered; update 1 clk after the causing beat.
// CONFIGURATION
//  - NSDP_ERR_COUNT_EN defined:
//    * adds output err_count [31:0]: number of tvalid beats with
//      chk_error!=0 while RUNNING;
//    * saturates at 32'hFFFFFFFF;
//    * cleared on accepted start and on reset.
//  - NSDP_ERR_COUNT_EN not defined: port and counter are absent.
// TESTING
//  - Reset, then idle 10 clks -> all outputs 0, run_status=0.
//  - start; send 3 packets of 4 beats, no errors -> chk_init 1 clk,
//    run_status=1, packets_rcvd=3, error=0.
//  - start mid-packet (beat 2 of 4), then 2 full packets -> the partial packet
//    is ignored; packets_rcvd=2.
//  - HALT_ON_ERR=1: chk_error=15'h0004 on beat 3 (tdata=512'hA5..) of packet 2,
//    then 5 more packets -> error=15'h0004, error_data=A5 pattern,
//    packets_rcvd=1, run_status=0.
//  - Simultaneous start&stop while RUNNING, packets_rcvd=7 -> IDLE,
//    packets_rcvd stays 7, no chk_init pulse.
//  - ACT_TIMEOUT=16: one beat, then idle -> eth_active=1 for 16 clks, then 0.
//    Repeat with NSDP_ERR_COUNT_EN: 3 error beats -> err_count=3.

Source files
------------

// File: rtl/nsdp_check_ctrl.sv
// nsdp_check_ctrl: run controller for the NSDP packet checker.
// Starts and stops check runs and aligns each run to a packet boundary.
// Counts completed packets and latches the first error with its data beat.
// Optional build macro NSDP_ERR_COUNT_EN adds err_count_o, a saturating
// count of error beats seen while running.

module nsdp_check_ctrl #(
  parameter int DW          = 512,
  parameter int EW          = 15,
  parameter bit HALT_ON_ERR = 1'b1,
  parameter int ACT_TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [DW-1:0] axis_tdata_i,
  input  logic          axis_tvalid_i,
  input  logic          axis_tlast_i,
  input  logic [EW-1:0] chk_error_i,
  output logic          chk_init_o,
  output logic          run_status_o,
  output logic          eth_active_o,
  output logic [EW-1:0] error_o,
  output logic [DW-1:0] error_data_o,
  output logic [63:0]   packets_rcvd_o
`ifdef NSDP_ERR_COUNT_EN
  ,
  output logic [31:0]   err_count_o
`endif
);

  localparam int ACT_W = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT + 1) : 1;
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUNNING,
    ST_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic              sop_q, sop_d;
  logic              chkInit_q, chkInit_d;
  logic              runStatus_q, runStatus_d;
  logic              ethActive_q, ethActive_d;
  logic [ACT_W-1:0]  actCount_q, actCount_d;
  logic [EW-1:0]     error_q, error_d;
  logic [DW-1:0]     errorData_q, errorData_d;
  logic [63:0]       packetsRcvd_q, packetsRcvd_d;

  logic inRun;
  logic stopReq;
  logic startReq;
  logic beatProcess;
  logic errHit;
  logic firstErr;

  // Decode the control requests and whether this beat belongs to the run
  always_comb begin
    inRun       = (state_q == ST_ARMED) || (state_q == ST_RUNNING);
    stopReq     = stop_i && inRun;
    startReq    = start_i && !stop_i;
    beatProcess = axis_tvalid_i && !startReq && !stopReq &&
                  ((state_q == ST_RUNNING) || ((state_q == ST_ARMED) && sop_q));
    errHit      = beatProcess && (chk_error_i != '0);
    firstErr    = errHit && (error_q == '0);
  end

  // Next-state logic for the run FSM
  always_comb begin
    state_d = state_q;
    if (stopReq) begin
      state_d = ST_IDLE;
    end else if (startReq) begin
      state_d = ST_ARMED;
    end else if (beatProcess) begin
      if (firstErr && HALT_ON_ERR) begin
        state_d = ST_HALTED;
      end else begin
        state_d = ST_RUNNING;
      end
    end
    runStatus_d = (state_d == ST_ARMED) || (state_d == ST_RUNNING);
  end

  // Run results: clear on accepted start, otherwise count packets and latch the first error
  always_comb begin
    chkInit_d     = 1'b0;
    error_d       = error_q;
    errorData_d   = errorData_q;
    packetsRcvd_d = packetsRcvd_q;
    if (startReq) begin
      chkInit_d     = 1'b1;
      error_d       = '0;
      errorData_d   = '0;
      packetsRcvd_d = '0;
    end else if (beatProcess) begin
      if (axis_tlast_i) begin
        packetsRcvd_d = packetsRcvd_q + 64'd1;
      end
      if (firstErr) begin
        error_d     = chk_error_i;
        errorData_d = axis_tdata_i;
      end
    end
  end

  // Packet-boundary tracking and link activity timer, independent of run state
  always_comb begin
    sop_d      = sop_q;
    actCount_d = actCount_q;
    if (axis_tvalid_i) begin
      sop_d      = axis_tlast_i;
      actCount_d = ACT_LOAD;
    end else if (actCount_q != '0) begin
      actCount_d = actCount_q - 1'b1;
    end
    ethActive_d = (actCount_d != '0);
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      sop_q         <= 1'b1;
      chkInit_q     <= 1'b0;
      runStatus_q   <= 1'b0;
      ethActive_q   <= 1'b0;
      actCount_q    <= '0;
      error_q       <= '0;
      errorData_q   <= '0;
      packetsRcvd_q <= '0;
    end else begin
      state_q       <= state_d;
      sop_q         <= sop_d;
      chkInit_q     <= chkInit_d;
      runStatus_q   <= runStatus_d;
      ethActive_q   <= ethActive_d;
      actCount_q    <= actCount_d;
      error_q       <= error_d;
      errorData_q   <= errorData_d;
      packetsRcvd_q <= packetsRcvd_d;
    end
  end

  assign chk_init_o     = chkInit_q;
  assign run_status_o   = runStatus_q;
  assign eth_active_o   = ethActive_q;
  assign error_o        = error_q;
  assign error_data_o   = errorData_q;
  assign packets_rcvd_o = packetsRcvd_q;

`ifdef NSDP_ERR_COUNT_EN
  logic [31:0] errCount_q, errCount_d;

  // Saturating count of every error beat seen while running, not just the first
  always_comb begin
    errCount_d = errCount_q;
    if (startReq) begin
      errCount_d = '0;
    end else if (errHit && (errCount_q != 32'hFFFF_FFFF)) begin
      errCount_d = errCount_q + 32'd1;
    end
  end

  // Error count register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errCount_d;
    end
  end

  assign err_count_o = errCount_q;
`endif

endmodule

// File: tb/tb_nsdp_check_ctrl.sv
// tb_nsdp_check_ctrl: directed bench for nsdp_check_ctrl.
// Two instances share the stimulus: dutH halts on the first error,
// dutR keeps running. ACT_TIMEOUT is shortened to 16 for the activity test.

module tb_nsdp_check_ctrl;

  localparam int DW = 512;
  localparam int EW = 15;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          stop;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [EW-1:0] chkError;

  logic          chkInitH, runStatusH, ethActiveH;
  logic [EW-1:0] errorH;
  logic [DW-1:0] errorDataH;
  logic [63:0]   packetsH;
  logic          chkInitR, runStatusR, ethActiveR;
  logic [EW-1:0] errorR;
  logic [DW-1:0] errorDataR;
  logic [63:0]   packetsR;
`ifdef NSDP_ERR_COUNT_EN
  logic [31:0]   errCountH, errCountR;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] dataA5;
  logic [DW-1:0] data5A;
  logic [DW-1:0] data3C;

  nsdp_check_ctrl #(
    .DW(DW), .EW(EW), .HALT_ON_ERR(1'b1), .ACT_TIMEOUT(16)
  ) dutH (
    .clk(clk), .resetn(resetn), .start_i(start), .stop_i(stop),
    .axis_tdata_i(tdata), .axis_tvalid_i(tvalid), .axis_tlast_i(tlast),
    .chk_error_i(chkError), .chk_init_o(chkInitH), .run_status_o(runStatusH),
    .eth_active_o(ethActiveH), .error_o(errorH), .error_data_o(errorDataH),
    .packets_rcvd_o(packetsH)
`ifdef NSDP_ERR_COUNT_EN
    , .err_count_o(errCountH)
`endif
  );

  nsdp_check_ctrl #(
    .DW(DW), .EW(EW), .HALT_ON_ERR(1'b0), .ACT_TIMEOUT(16)
  ) dutR (
    .clk(clk), .resetn(resetn), .start_i(start), .stop_i(stop),
    .axis_tdata_i(tdata), .axis_tvalid_i(tvalid), .axis_tlast_i(tlast),
    .chk_error_i(chkError), .chk_init_o(chkInitR), .run_status_o(runStatusR),
    .eth_active_o(ethActiveR), .error_o(errorR), .error_data_o(errorDataR),
    .packets_rcvd_o(packetsR)
`ifdef NSDP_ERR_COUNT_EN
    , .err_count_o(errCountR)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run never reaches its end
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; outputs are valid #1 after the edge on return
  task automatic applyStimulus(input logic vld, input logic lst,
                               input logic [DW-1:0] data, input logic [EW-1:0] err,
                               input logic st, input logic sp);
    tvalid   = vld;
    tlast    = lst;
    tdata    = data;
    chkError = err;
    start    = st;
    stop     = sp;
    @(posedge clk);
    #1;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdata    = '0;
    chkError = '0;
    start    = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic sendPacket(input int nBeats, input int errBeat,
                            input logic [EW-1:0] errVal, input logic [DW-1:0] errData);
    for (int b = 1; b <= nBeats; b++) begin
      applyStimulus(1'b1, b == nBeats,
                    (b == errBeat) ? errData : DW'(b),
                    (b == errBeat) ? errVal : '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    dataA5   = {64{8'hA5}};
    data5A   = {64{8'h5A}};
    data3C   = {64{8'h3C}};
    resetn   = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    tdata    = '0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    chkError = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state after 10 idle clocks
    idleCycles(10);
    checkOutput("rst_runStatus", runStatusH, 1'b0);
    checkOutput("rst_chkInit", chkInitH, 1'b0);
    checkOutput("rst_ethActive", ethActiveH, 1'b0);
    checkOutput("rst_error", errorH, '0);
    checkOutput("rst_errorData", errorDataH, '0);
    checkOutput("rst_packets", packetsR, '0);

    // Clean run of three 4-beat packets
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("start_chkInit", chkInitH, 1'b1);
    checkOutput("start_runStatus", runStatusH, 1'b1);
    idleCycles(1);
    checkOutput("chkInit_oneCycle", chkInitH, 1'b0);
    repeat (3) sendPacket(4, 0, '0, '0);
    checkOutput("clean_packetsH", packetsH, 64'd3);
    checkOutput("clean_packetsR", packetsR, 64'd3);
    checkOutput("clean_error", errorH, '0);
    checkOutput("clean_runStatus", runStatusH, 1'b1);
    checkOutput("clean_ethActive", ethActiveH, 1'b1);

    // Restart on beat 2 of a packet: the rest of that packet is ignored
    applyStimulus(1'b1, 1'b0, DW'(1), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, DW'(2), '0, 1'b1, 1'b0);
    checkOutput("mid_chkInit", chkInitH, 1'b1);
    checkOutput("mid_cleared", packetsH, 64'd0);
    applyStimulus(1'b1, 1'b0, DW'(3), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, DW'(4), '0, 1'b0, 1'b0);
    checkOutput("mid_partialIgnored", packetsH, 64'd0);
    checkOutput("mid_armed", runStatusH, 1'b1);
    repeat (2) sendPacket(4, 0, '0, '0);
    checkOutput("mid_packetsH", packetsH, 64'd2);
    checkOutput("mid_packetsR", packetsR, 64'd2);

    // Error on beat 3 of packet 2, then 5 more packets (one with a later error)
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    sendPacket(4, 0, '0, '0);
    applyStimulus(1'b1, 1'b0, DW'(1), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, DW'(2), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, dataA5, 15'h0004, 1'b0, 1'b0);
    checkOutput("err_latchH", errorH, 15'h0004);
    checkOutput("err_dataH", errorDataH, dataA5);
    checkOutput("err_haltedH", runStatusH, 1'b0);
    checkOutput("err_latchR", errorR, 15'h0004);
    checkOutput("err_runningR", runStatusR, 1'b1);
    applyStimulus(1'b1, 1'b1, DW'(4), '0, 1'b0, 1'b0);
    sendPacket(4, 0, '0, '0);
    sendPacket(4, 0, '0, '0);
    sendPacket(4, 2, 15'h0100, data3C);
    sendPacket(4, 0, '0, '0);
    sendPacket(4, 0, '0, '0);
    checkOutput("halt_packetsH", packetsH, 64'd1);
    checkOutput("halt_errorH", errorH, 15'h0004);
    checkOutput("halt_dataH", errorDataH, dataA5);
    checkOutput("halt_runStatusH", runStatusH, 1'b0);
    checkOutput("noHalt_packetsR", packetsR, 64'd7);
    checkOutput("noHalt_errorSticky", errorR, 15'h0004);
    checkOutput("noHalt_dataSticky", errorDataR, dataA5);
    checkOutput("noHalt_runStatusR", runStatusR, 1'b1);
`ifdef NSDP_ERR_COUNT_EN
    checkOutput("errCount_haltH", errCountH, 32'd1);
    checkOutput("errCount_noHaltR", errCountR, 32'd2);
`endif

    // Simultaneous start and stop: stop wins
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("startStop_runStatusR", runStatusR, 1'b0);
    checkOutput("startStop_packetsR", packetsR, 64'd7);
    checkOutput("startStop_chkInitR", chkInitR, 1'b0);
    checkOutput("startStop_chkInitH", chkInitH, 1'b0);
    checkOutput("startStop_errorHeldH", errorH, 15'h0004);
    sendPacket(4, 0, '0, '0);
    checkOutput("idle_noCountR", packetsR, 64'd7);
    checkOutput("halted_noCountH", packetsH, 64'd1);

    // Error on a tlast beat: packet counted and error latched together
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("restart_clearPackets", packetsR, 64'd0);
    checkOutput("restart_clearError", errorR, '0);
    checkOutput("restart_clearData", errorDataR, '0);
    checkOutput("restart_fromHaltedInit", chkInitH, 1'b1);
    checkOutput("restart_fromHaltedRun", runStatusH, 1'b1);
    sendPacket(2, 2, 15'h0010, data5A);
    checkOutput("lastErr_packetsH", packetsH, 64'd1);
    checkOutput("lastErr_errorH", errorH, 15'h0010);
    checkOutput("lastErr_dataH", errorDataH, data5A);
    checkOutput("lastErr_runStatusH", runStatusH, 1'b0);
    checkOutput("lastErr_packetsR", packetsR, 64'd1);
    checkOutput("lastErr_errorR", errorR, 15'h0010);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("stop_runStatusR", runStatusR, 1'b0);
    checkOutput("stop_packetsHeld", packetsR, 64'd1);
    checkOutput("stop_errorHeld", errorR, 15'h0010);

    // Activity timer: high for exactly 16 clocks after a single beat
    idleCycles(20);
    checkOutput("act_quiet", ethActiveH, 1'b0);
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    checkOutput("act_rise", ethActiveH, 1'b1);
    idleCycles(15);
    checkOutput("act_hold16", ethActiveR, 1'b1);
    idleCycles(1);
    checkOutput("act_drop", ethActiveH, 1'b0);

    // Three error beats in one packet
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
`ifdef NSDP_ERR_COUNT_EN
    checkOutput("errCount_clearR", errCountR, 32'd0);
`endif
    applyStimulus(1'b1, 1'b0, DW'(1), 15'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, DW'(2), 15'h0002, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, DW'(3), 15'h0003, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, DW'(4), '0, 1'b0, 1'b0);
    checkOutput("multi_packetsH", packetsH, 64'd0);
    checkOutput("multi_errorH", errorH, 15'h0001);
    checkOutput("multi_packetsR", packetsR, 64'd1);
    checkOutput("multi_errorR", errorR, 15'h0001);
    checkOutput("multi_dataR", errorDataR, DW'(1));
`ifdef NSDP_ERR_COUNT_EN
    checkOutput("multi_errCountH", errCountH, 32'd1);
    checkOutput("multi_errCountR", errCountR, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
